// File: rtl/clk_counter_leds_if.sv
// LED counter board-side signals: count enable in, green LED bank out.
// The master side is the board top; the counter sits on the slave side.
interface clk_counter_leds_if #(
   parameter int LEDG_SIZE = 8
);
   logic                 EN_N;
   logic [LEDG_SIZE-1:0] LEDG;

   modport master (output EN_N, input LEDG);
   modport slave  (input EN_N, output LEDG);
endinterface

// File: rtl/clk_counter_leds.sv
// Divides EXTCLK to a 5 Hz tick and shows a binary count on LEDG with a wrap strobe on the top LED.
// LED count steps COUNT_FREQ enabled edges after the last step; EN_N high freezes the phase.
module clk_counter_leds #(
   parameter int  EXT_CLOCK_FREQ   = 50_000_000,
   parameter real EXT_CLOCK_PERIOD = 20.000,
   parameter int  LEDG_SIZE        = 8
) (
   input  logic              EXTCLK,
   input  logic              RST,
   clk_counter_leds_if.slave io
);
   localparam int COUNT_FREQ  = EXT_CLOCK_FREQ / 5;
   localparam int COUNT_WIDTH = $clog2(COUNT_FREQ);
   localparam int LED_CNTR_W  = LEDG_SIZE - 1;

   if (LEDG_SIZE < 2 || COUNT_FREQ < 2 || EXT_CLOCK_PERIOD <= 0.0) begin : g_bad_param
      $error("clk_counter_leds: unsupported parameter set");
   end

   logic [COUNT_WIDTH-1:0] clk_counter, clk_counter_d;
   logic [LED_CNTR_W-1:0]  led_counter, led_counter_d;
   logic                   overflow,    overflow_d;

   always_comb begin
      clk_counter_d = clk_counter;
      led_counter_d = led_counter;
      overflow_d    = 1'b0;
      if (!io.EN_N) begin
         if (clk_counter == COUNT_WIDTH'(COUNT_FREQ - 1)) begin
            clk_counter_d = '0;
            led_counter_d = led_counter + 1'b1;
            // Strobe only on the all-ones to zero wrap of the LED count.
            overflow_d    = &led_counter;
         end else begin
            clk_counter_d = clk_counter + 1'b1;
         end
      end
   end

   always_ff @(posedge EXTCLK) begin
      if (RST) begin
         clk_counter <= '0;
         led_counter <= '0;
         overflow    <= 1'b0;
      end else begin
         clk_counter <= clk_counter_d;
         led_counter <= led_counter_d;
         overflow    <= overflow_d;
      end
   end

   assign io.LEDG = {overflow, led_counter};

   a_clk_step: assert property (@(posedge EXTCLK) disable iff (RST)
      !io.EN_N |=> ((int'(clk_counter) == int'($past(clk_counter)) + 1) ||
                    (int'($past(clk_counter)) == COUNT_FREQ - 1 && clk_counter == '0)));

   a_led_step: assert property (@(posedge EXTCLK) disable iff (RST)
      (!io.EN_N && int'(clk_counter) == COUNT_FREQ - 1)
         |=> (led_counter == LED_CNTR_W'($past(led_counter) + 1'b1)));

   a_ovf_pulse: assert property (@(posedge EXTCLK) disable iff (RST)
      overflow |=> !overflow);

   a_led_hold: assert property (@(posedge EXTCLK) disable iff (RST)
      io.EN_N |=> $stable(led_counter));
endmodule

// File: tb/tb_clk_counter_leds.sv
// Bench for clk_counter_leds with a 10-clock tick period so wraps are reachable quickly.
module tb_clk_counter_leds;
   localparam int FREQ = 50;

   logic extclk = 1'b0;
   logic rst    = 1'b1;

   clk_counter_leds_if #(.LEDG_SIZE(8)) led_if();

   clk_counter_leds #(
      .EXT_CLOCK_FREQ  (FREQ),
      .EXT_CLOCK_PERIOD(20.0),
      .LEDG_SIZE       (8)
   ) dut (
      .EXTCLK(extclk),
      .RST   (rst),
      .io    (led_if)
   );

   always #10 extclk = ~extclk;

   typedef struct {
      string      name;
      logic       rst;
      logic       en_n;
      int         cycles;
      logic [7:0] ledg;
      int         cnt;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] ledg;
      int         cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check({e.name, "_ledg"}, int'(led_if.LEDG), int'(e.ledg));
         check({e.name, "_cnt"}, int'(dut.clk_counter), e.cnt);
      end
   endtask

   task automatic add(input string n, input logic r, input logic en, input int c,
                      input logic [7:0] l, input int k);
      vec_t v;
      v.name = n; v.rst = r; v.en_n = en; v.cycles = c; v.ledg = l; v.cnt = k;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge extclk);
      rst         = v.rst;
      led_if.EN_N = v.en_n;
      e.name = v.name; e.ledg = v.ledg; e.cnt = v.cnt;
      sb.push_back(e);
      repeat (v.cycles) @(posedge extclk);
      #1;
      compare_head();
   endtask

   initial begin
      int   split;
      int   ovf_seen;
      exp_t e;

      led_if.EN_N = 1'b0;

      // Tick period is FREQ/5 = 10 clocks.
      add("rst_hold",     1'b1, 1'b0,   10, 8'h00, 0);
      add("idle_hold",    1'b0, 1'b1,   20, 8'h00, 0);
      add("first_tick",   1'b0, 1'b0,   15, 8'h01, 5);
      add("tick2",        1'b0, 1'b0,   10, 8'h02, 5);
      add("tick3",        1'b0, 1'b0,   10, 8'h03, 5);
      add("tick4",        1'b0, 1'b0,   10, 8'h04, 5);
      add("tick5",        1'b0, 1'b0,   10, 8'h05, 5);
      add("hold_mid",     1'b0, 1'b1,   10, 8'h05, 5);
      add("run_to_edge",  1'b0, 1'b0,    4, 8'h05, 9);
      add("hold_at_edge", 1'b0, 1'b1,   10, 8'h05, 9);
      add("resume",       1'b0, 1'b0,    1, 8'h06, 0);
      add("run_7e",       1'b0, 1'b0, 1200, 8'h7E, 0);
      add("run_7f",       1'b0, 1'b0,   10, 8'h7F, 0);
      split = vecs.size();
      add("rst_clear",    1'b1, 1'b0,    1, 8'h00, 0);
      add("run_pre_wrap", 1'b0, 1'b0, 1279, 8'h7F, 9);
      add("rst_kills_ovf",1'b1, 1'b0,    1, 8'h00, 0);
      add("post_rst",     1'b0, 1'b1,    5, 8'h00, 0);

      for (int i = 0; i < split; i++) apply(vecs[i]);

      // Cycle-by-cycle through the wrap from 7F: overflow must pulse once.
      @(negedge extclk);
      rst         = 1'b0;
      led_if.EN_N = 1'b0;
      ovf_seen    = 0;
      for (int k = 1; k <= 12; k++) begin
         e.name = $sformatf("wrap_c%0d", k);
         e.ledg = {k == 10, (k < 10) ? 7'h7F : 7'h00};
         e.cnt  = k % 10;
         sb.push_back(e);
         @(posedge extclk);
         #1;
         ovf_seen += int'(led_if.LEDG[7]);
         compare_head();
      end
      check("ovf_pulse_count", ovf_seen, 1);

      for (int i = split; i < vecs.size(); i++) apply(vecs[i]);

      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
